// File: rtl/rv32i_mem_arbiter.sv
// Unified-memory arbiter for the 3-stage RV32I core: LSU has priority over fetch,
// one outstanding transaction, store lane steering, load extraction and a response timeout.
module rv32i_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  // state    | meaning
  // IDLE     | arbitrate; drive memory request from the winner
  // WAIT_IF  | fetch granted, waiting for instruction word or timeout
  // WAIT_LSU | load/store granted, waiting for data/ack or timeout
  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_LSU} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             grant_lsu;
  logic             lat_we;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_off;

  logic             lsu_misalign, lsu_illegal;
  logic [1:0]       lsu_off;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;

  assign lsu_off = lsu_addr[1:0];

  always_comb begin
    lsu_misalign = 1'b0;
    lsu_illegal  = 1'b0;
    case (lsu_funct3[1:0])
      2'b01:   lsu_misalign = lsu_off[0];
      2'b10:   lsu_misalign = (lsu_off != 2'b00);
      default: lsu_misalign = 1'b0;
    endcase
    if (lsu_we) lsu_illegal = (lsu_funct3 >= 3'd3);
    else        lsu_illegal = (lsu_funct3 == 3'd3) || (lsu_funct3 == 3'd6) || (lsu_funct3 == 3'd7);
  end

  // Store data is replicated across lanes so the memory only needs byte enables.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = lsu_wdata;
    case (lsu_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << lsu_off;
        st_wdata = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << lsu_off;
        st_wdata = {2{lsu_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = lsu_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{lat_off, 3'b000} +: 8];
    ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'h0, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    grant_lsu  = 1'b0;
    if_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    if_err     = 1'b0;
    lsu_gnt    = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    lsu_err    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'h0;
    mem_addr   = '0;
    mem_wdata  = '0;
    // Outputs are held quiet while reset is asserted, even in IDLE with live requests.
    if (!rst) begin
      case (state)
        IDLE: begin
          cnt_nx = '0;
          if (lsu_req) begin
            if (lsu_misalign || lsu_illegal) begin
              lsu_gnt = 1'b1;
              lsu_err = 1'b1;
            end else begin
              mem_req   = 1'b1;
              mem_we    = lsu_we;
              mem_be    = lsu_we ? st_be : 4'hF;
              mem_addr  = {lsu_addr[ADDR_W-1:2], 2'b00};
              mem_wdata = lsu_we ? st_wdata : 32'h0;
              if (mem_gnt) begin
                lsu_gnt   = 1'b1;
                grant_lsu = 1'b1;
                state_nx  = WAIT_LSU;
              end
            end
          end else if (if_req) begin
            if (if_addr[1:0] != 2'b00) begin
              if_gnt = 1'b1;
              if_err = 1'b1;
            end else begin
              mem_req  = 1'b1;
              mem_be   = 4'hF;
              mem_addr = {if_addr[ADDR_W-1:2], 2'b00};
              if (mem_gnt) begin
                if_gnt   = 1'b1;
                state_nx = WAIT_IF;
              end
            end
          end
        end
        WAIT_IF: begin
          cnt_nx = cnt + CNT_W'(1);
          if (mem_rvalid) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
            state_nx  = IDLE;
          end else if (cnt == TO_LAST) begin
            if_err   = 1'b1;
            state_nx = IDLE;
          end
        end
        WAIT_LSU: begin
          cnt_nx = cnt + CNT_W'(1);
          if (mem_rvalid) begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = lat_we ? 32'h0 : ld_data;
            state_nx   = IDLE;
          end else if (cnt == TO_LAST) begin
            lsu_err  = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_off    <= 2'b00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (grant_lsu) begin
        lat_we     <= lsu_we;
        lat_funct3 <= lsu_funct3;
        lat_off    <= lsu_off;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: fetch, contention, store lanes, load extension,
// error paths, timeout and reset-in-wait, with hand-computed expectations.
module tb_rv32i_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid, if_err;
  logic [31:0]       if_rdata;
  logic              lsu_req, lsu_we;
  logic [2:0]        lsu_funct3;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic              lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0]       lsu_rdata;
  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt, mem_rvalid;
  logic [31:0]       mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {22'h0, if_gnt, if_rvalid, if_err, lsu_gnt, lsu_rvalid, lsu_err,
            mem_req, mem_we, mem_be[1:0]} | {28'h0, mem_be[3:2], 2'b00};
  endfunction

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    lsu_req = 0; lsu_we = 0; lsu_funct3 = 3'd0; lsu_addr = '0; lsu_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic lsu_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                         input logic [3:0] be_e, input logic [31:0] wd_e, input logic [31:0] rd_e);
    tick();
    lsu_req = 1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata; mem_gnt = 1;
    @(negedge clk);
    chk({tag, "_gnt"},   32'(lsu_gnt), 32'd1);
    chk({tag, "_req"},   32'(mem_req), 32'd1);
    chk({tag, "_we"},    32'(mem_we), 32'(we));
    chk({tag, "_be"},    32'(mem_be), 32'(be_e));
    chk({tag, "_wdata"}, mem_wdata, wd_e);
    chk({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
    tick();
    lsu_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = rd;
    @(negedge clk);
    chk({tag, "_rvalid"}, 32'(lsu_rvalid), 32'd1);
    chk({tag, "_rdata"},  lsu_rdata, rd_e);
    chk({tag, "_err"},    32'(lsu_err), 32'd0);
    tick();
    mem_rvalid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    clear_inputs();
    // Reset with live requests: every output must stay 0.
    rst = 1; if_req = 1; if_addr = 32'h100; lsu_req = 1; lsu_funct3 = 3'd2; lsu_addr = 32'h200;
    mem_gnt = 1;
    tick();
    @(negedge clk);
    chk("rst_ctrl", ctrl_vec(), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    tick();
    clear_inputs();
    rst = 0;

    // Plain fetch
    tick();
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    @(negedge clk);
    chk("fetch_gnt", 32'(if_gnt), 32'd1);
    chk("fetch_addr", mem_addr, 32'h100);
    chk("fetch_be", 32'(mem_be), 32'hF);
    chk("fetch_lsu_gnt", 32'(lsu_gnt), 32'd0);
    tick();
    if_req = 0; mem_gnt = 0;
    @(negedge clk);
    chk("fetch_wait_req", 32'(mem_req), 32'd0);
    chk("fetch_wait_rv", 32'(if_rvalid), 32'd0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    @(negedge clk);
    chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
    chk("fetch_rdata", if_rdata, 32'h00500093);
    chk("fetch_lsu_rv", 32'(lsu_rvalid), 32'd0);
    tick();
    mem_rvalid = 0;

    // Contention: LSU first, IF in the IDLE cycle after lsu_rvalid
    tick();
    if_req = 1; if_addr = 32'h104; lsu_req = 1; lsu_we = 0; lsu_funct3 = 3'd2; lsu_addr = 32'h200;
    mem_gnt = 1;
    @(negedge clk);
    chk("cont_lsu_gnt", 32'(lsu_gnt), 32'd1);
    chk("cont_if_gnt0", 32'(if_gnt), 32'd0);
    chk("cont_addr0", mem_addr, 32'h200);
    tick();
    lsu_req = 0;
    @(negedge clk);
    chk("cont_wait_req", 32'(mem_req), 32'd0);
    chk("cont_if_gnt1", 32'(if_gnt), 32'd0);
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h11223344;
    @(negedge clk);
    chk("cont_lsu_rv", 32'(lsu_rvalid), 32'd1);
    chk("cont_lsu_rdata", lsu_rdata, 32'h11223344);
    chk("cont_if_gnt2", 32'(if_gnt), 32'd0);
    tick();
    mem_rvalid = 0; mem_gnt = 1;
    @(negedge clk);
    chk("cont_if_gnt3", 32'(if_gnt), 32'd1);
    chk("cont_addr1", mem_addr, 32'h104);
    tick();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00000013;
    @(negedge clk);
    chk("cont_if_rv", 32'(if_rvalid), 32'd1);
    tick();
    mem_rvalid = 0;

    // Store lanes
    lsu_txn("sb", 1'b1, 3'd0, 32'h203, 32'h000000AB, 32'h0, 4'b1000, 32'hABABABAB, 32'h0);
    lsu_txn("sh", 1'b1, 3'd1, 32'h202, 32'h00001234, 32'h0, 4'b1100, 32'h12341234, 32'h0);
    lsu_txn("sw", 1'b1, 3'd2, 32'h204, 32'hDEADBEEF, 32'h0, 4'hF, 32'hDEADBEEF, 32'h0);
    // Load extension
    lsu_txn("lb1",  1'b0, 3'd0, 32'h201, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'h0000007F);
    lsu_txn("lb2",  1'b0, 3'd0, 32'h202, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'hFFFFFFFF);
    lsu_txn("lbu3", 1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'h00000080);
    lsu_txn("lh2",  1'b0, 3'd1, 32'h202, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'hFFFF80FF);
    lsu_txn("lhu0", 1'b0, 3'd5, 32'h200, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'h00007F01);
    lsu_txn("lw",   1'b0, 3'd2, 32'h200, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'h80FF7F01);

    // Misaligned LW with fetch pending
    tick();
    lsu_req = 1; lsu_we = 0; lsu_funct3 = 3'd2; lsu_addr = 32'h201; if_req = 1; if_addr = 32'h108;
    mem_gnt = 1;
    @(negedge clk);
    chk("mis_gnt", 32'(lsu_gnt), 32'd1);
    chk("mis_err", 32'(lsu_err), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    lsu_req = 0;
    @(negedge clk);
    chk("mis_if_next", 32'(if_gnt), 32'd1);
    chk("mis_if_addr", mem_addr, 32'h108);
    tick();
    if_req = 0; mem_gnt = 0; mem_rvalid = 1;
    @(negedge clk);
    chk("mis_if_rv", 32'(if_rvalid), 32'd1);
    tick();
    mem_rvalid = 0;

    // Illegal load funct3 and misaligned fetch
    tick();
    lsu_req = 1; lsu_we = 0; lsu_funct3 = 3'd3; lsu_addr = 32'h200; mem_gnt = 1;
    @(negedge clk);
    chk("ill_err", 32'(lsu_err), 32'd1);
    chk("ill_req", 32'(mem_req), 32'd0);
    tick();
    lsu_req = 0; if_req = 1; if_addr = 32'h102;
    @(negedge clk);
    chk("if_mis_ctrl", ctrl_vec(), 32'h00000280);
    tick();
    if_req = 0; mem_gnt = 0;

    // Timeout
    tick();
    lsu_req = 1; lsu_we = 0; lsu_funct3 = 3'd2; lsu_addr = 32'h200; mem_gnt = 1;
    @(negedge clk);
    chk("to_gnt", 32'(lsu_gnt), 32'd1);
    k = 0;
    for (int i = 1; i <= TIMEOUT + 10; i++) begin
      tick();
      lsu_req = 0; mem_gnt = 0;
      @(negedge clk);
      k = i;
      if (lsu_err) break;
    end
    chk("to_cycles", 32'(k), 32'(TIMEOUT));
    tick();
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("to_late_ctrl", ctrl_vec(), 32'h0);
    tick();
    mem_rvalid = 0;

    // Reset while in WAIT_IF
    tick();
    if_req = 1; if_addr = 32'h300; mem_gnt = 1;
    @(negedge clk);
    chk("rw_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 0; mem_gnt = 0; rst = 1; mem_rvalid = 1;
    @(negedge clk);
    chk("rw_rst_ctrl", ctrl_vec(), 32'h0);
    tick();
    rst = 0; mem_rvalid = 1;
    @(negedge clk);
    chk("rw_after_ctrl", ctrl_vec(), 32'h0);
    chk("rw_after_data", if_rdata | lsu_rdata | mem_wdata | mem_addr, 32'h0);
    tick();
    mem_rvalid = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
